// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter: count mode selection and one-shot FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } mode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/counter_nxt_calc.sv
// Combinational next-count arithmetic: candidate = count +/- step at full width,
// then wrap/saturate against [MIN_VAL, MAX_VAL] and report bound events.
module counter_nxt_calc
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 1023,
    parameter int unsigned STEP_W  = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic              updown,
    input  logic [STEP_W-1:0] step,
    input  mode_t             mode,
    output logic [WIDTH-1:0]  nxt,
    output logic              hit,
    output logic              ovf,
    output logic              udf
);

    localparam int unsigned CW = WIDTH + STEP_W + 1;
    localparam logic [CW-1:0] MIN_C = CW'(MIN_VAL);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_VAL);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [CW-1:0] cnt_c;
    logic [CW-1:0] step_c;
    logic [CW-1:0] up_c;
    logic [CW-1:0] floor_c;
    logic [CW-1:0] res;
    logic          clip;

    always_comb begin
        cnt_c   = CW'(count);
        step_c  = CW'(step);
        up_c    = cnt_c + step_c;
        // Down direction is tested as count vs MIN_VAL+step so nothing goes negative.
        floor_c = MIN_C + step_c;
        clip    = (mode == MODE_SAT) || (mode == MODE_ONESHOT);
        res     = cnt_c;
        hit     = 1'b0;
        ovf     = 1'b0;
        udf     = 1'b0;
        if (step_c != '0) begin
            if (updown) begin
                hit = (up_c >= MAX_C);
                if (up_c > MAX_C) begin
                    ovf = 1'b1;
                    res = clip ? MAX_C : MIN_C + (up_c - MAX_C - ONE_C);
                end else begin
                    res = up_c;
                end
            end else begin
                hit = (cnt_c <= floor_c);
                if (cnt_c < floor_c) begin
                    udf = 1'b1;
                    res = clip ? MIN_C : MAX_C + ONE_C - (floor_c - cnt_c);
                end else begin
                    res = cnt_c - step_c;
                end
            end
        end
        nxt = WIDTH'(res);
    end

endmodule

// File: rtl/counter_updown_param.sv
// Parameterised up/down counter with wrap/saturate/one-shot modes, sticky
// overflow/underflow flags and a registered terminal-count pulse.
module counter_updown_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned MIN_VAL    = 0,
    parameter int unsigned MAX_VAL    = 1023,
    parameter int unsigned PRESET_VAL = 253,
    parameter int unsigned STEP_W     = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              clr_in,
    input  logic              preset_in,
    input  logic              load_in,
    input  logic [WIDTH-1:0]  load_val_in,
    input  logic              en_in,
    input  logic              updown_in,
    input  logic [STEP_W-1:0] step_in,
    input  logic [1:0]        mode_in,
    output logic [WIDTH-1:0]  count_out,
    output logic              tc_out,
    output logic              ovf_out,
    output logic              udf_out,
    output logic              done_out
);

    localparam logic [WIDTH-1:0] MIN_T    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_T    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] PRESET_T = WIDTH'(PRESET_VAL);

    state_t           state_q;
    state_t           state_d;
    mode_t            mode;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] nxt;
    logic             tc_d;
    logic             ovf_d;
    logic             udf_d;
    logic             hit;
    logic             ovf_evt;
    logic             udf_evt;
    logic             below;
    logic             above;

    assign mode = mode_t'(mode_in);

    // Borrow bits of the widened differences give the clamp decisions.
    assign below = 1'(({1'b0, load_val_in} - {1'b0, MIN_T}) >> WIDTH);
    assign above = 1'(({1'b0, MAX_T} - {1'b0, load_val_in}) >> WIDTH);

    counter_nxt_calc #(
        .WIDTH   (WIDTH),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_nxt_calc (
        .count  (count_out),
        .updown (updown_in),
        .step   (step_in),
        .mode   (mode),
        .nxt    (nxt),
        .hit    (hit),
        .ovf    (ovf_evt),
        .udf    (udf_evt)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_out;
        tc_d    = 1'b0;
        ovf_d   = ovf_out;
        udf_d   = udf_out;
        if (clr_in) begin
            state_d = ST_RUN;
            count_d = MIN_T;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (preset_in) begin
            state_d = ST_RUN;
            count_d = PRESET_T;
        end else if (load_in) begin
            state_d = ST_RUN;
            if (below)      count_d = MIN_T;
            else if (above) count_d = MAX_T;
            else            count_d = load_val_in;
        end else if (en_in && (state_q == ST_RUN)) begin
            count_d = nxt;
            tc_d    = hit;
            ovf_d   = ovf_out | ovf_evt;
            udf_d   = udf_out | udf_evt;
            if (hit && (mode == MODE_ONESHOT)) state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_RUN;
            count_out <= MIN_T;
            tc_out    <= 1'b0;
            ovf_out   <= 1'b0;
            udf_out   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_out <= count_d;
            tc_out    <= tc_d;
            ovf_out   <= ovf_d;
            udf_out   <= udf_d;
        end
    end

    assign done_out = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_updown_param.sv
// Bench for counter_updown_param: directed vector table, hand sequences and a
// randomized run against an arithmetic reference model (default and MAX_VAL=900).
module tb_counter_updown_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, preset, load, en, updown;
    logic [9:0] load_val;
    logic [3:0] step;
    logic [1:0] mode;

    logic [9:0] count_a, count_b;
    logic       tc_a, ovf_a, udf_a, done_a;
    logic       tc_b, ovf_b, udf_b, done_b;
    logic [13:0] outs_a, outs_b;

    int checks = 0;
    int errors = 0;

    longint m_cnt [2];
    bit     m_tc  [2];
    bit     m_ovf [2];
    bit     m_udf [2];
    bit     m_done[2];
    longint m_max [2] = '{1023, 900};
    localparam longint MINV = 0;
    localparam longint PRESETV = 253;

    always #5 clk = ~clk;

    counter_updown_param dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .clr_in(clr), .preset_in(preset),
        .load_in(load), .load_val_in(load_val), .en_in(en), .updown_in(updown),
        .step_in(step), .mode_in(mode), .count_out(count_a), .tc_out(tc_a),
        .ovf_out(ovf_a), .udf_out(udf_a), .done_out(done_a)
    );

    counter_updown_param #(.MAX_VAL(900)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .clr_in(clr), .preset_in(preset),
        .load_in(load), .load_val_in(load_val), .en_in(en), .updown_in(updown),
        .step_in(step), .mode_in(mode), .count_out(count_b), .tc_out(tc_b),
        .ovf_out(ovf_b), .udf_out(udf_b), .done_out(done_b)
    );

    assign outs_a = {count_a, tc_a, ovf_a, udf_a, done_a};
    assign outs_b = {count_b, tc_b, ovf_b, udf_b, done_b};

    typedef struct {
        bit c, p, l; int lv; bit e, ud; int st; int md;
        int cnt; bit tc, ovf, udf, done;
    } vec_t;
    vec_t tbl[20];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = MINV; m_tc[k] = 0; m_ovf[k] = 0; m_udf[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            longint mx;
            longint cand;
            mx = m_max[k];
            if (clr) begin
                m_cnt[k] = MINV; m_tc[k] = 0; m_ovf[k] = 0; m_udf[k] = 0; m_done[k] = 0;
            end else if (preset) begin
                m_cnt[k] = PRESETV; m_tc[k] = 0; m_done[k] = 0;
            end else if (load) begin
                m_cnt[k] = (longint'(load_val) > mx) ? mx :
                           (longint'(load_val) < MINV) ? MINV : longint'(load_val);
                m_tc[k] = 0; m_done[k] = 0;
            end else if (en && !m_done[k] && step != 0) begin
                cand = updown ? m_cnt[k] + longint'(step) : m_cnt[k] - longint'(step);
                m_tc[k] = updown ? (cand >= mx) : (cand <= MINV);
                if (cand > mx) begin
                    m_ovf[k] = 1;
                    m_cnt[k] = (mode == 2'd1 || mode == 2'd2) ? mx : MINV + (cand - mx - 1);
                end else if (cand < MINV) begin
                    m_udf[k] = 1;
                    m_cnt[k] = (mode == 2'd1 || mode == 2'd2) ? MINV : mx - (MINV - cand - 1);
                end else begin
                    m_cnt[k] = cand;
                end
                if (mode == 2'd2 && m_tc[k]) m_done[k] = 1;
            end else begin
                m_tc[k] = 0;
            end
        end
    endtask

    function automatic logic [13:0] model_vec(input int k);
        return {10'(m_cnt[k]), m_tc[k], m_ovf[k], m_udf[k], m_done[k]};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cnt=%0d tc=%b ovf=%b udf=%b done=%b, expected cnt=%0d tc=%b ovf=%b udf=%b done=%b",
                     name, act[13:4], act[3], act[2], act[1], act[0],
                     exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic tick(input string name);
        assert (longint'(step) <= m_max[1] - MINV + 1) else $error("illegal step %0d", step);
        @(posedge clk);
        if (!rst_n) model_reset(); else model_clock();
        #1;
        check({name, "_a"}, outs_a, model_vec(0));
        check({name, "_b"}, outs_b, model_vec(1));
    endtask

    task automatic idle();
        clr = 0; preset = 0; load = 0; en = 0; updown = 0; load_val = '0; step = '0; mode = '0;
    endtask

    initial begin
        int bias;
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_a", outs_a, 14'd0);
        check("reset_b", outs_b, 14'd0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;

        // Directed vectors (expectations for the default instance)
        tbl[0]  = '{0,0,1,1020,0,1,0,0, 1020,0,0,0,0};
        tbl[1]  = '{0,0,0,0,   1,1,5,0, 1,   1,1,0,0};
        tbl[2]  = '{0,0,0,0,   0,1,5,0, 1,   0,1,0,0};
        tbl[3]  = '{0,0,1,3,   0,0,4,1, 3,   0,1,0,0};
        tbl[4]  = '{0,0,0,0,   1,0,4,1, 0,   1,1,1,0};
        tbl[5]  = '{0,0,0,0,   1,0,4,1, 0,   1,1,1,0};
        tbl[6]  = '{1,0,0,0,   0,0,0,0, 0,   0,0,0,0};
        tbl[7]  = '{0,0,1,1021,0,1,1,2, 1021,0,0,0,0};
        tbl[8]  = '{0,0,0,0,   1,1,1,2, 1022,0,0,0,0};
        tbl[9]  = '{0,0,0,0,   1,1,1,2, 1023,1,0,0,1};
        tbl[10] = '{0,0,0,0,   1,1,1,2, 1023,0,0,0,1};
        tbl[11] = '{0,1,0,0,   1,1,1,2, 253, 0,0,0,0};
        tbl[12] = '{0,0,1,2,   0,0,5,0, 2,   0,0,0,0};
        tbl[13] = '{0,0,0,0,   1,0,5,0, 1021,1,0,1,0};
        tbl[14] = '{1,1,1,500, 1,1,5,0, 0,   0,0,0,0};
        tbl[15] = '{0,1,1,500, 0,0,0,0, 253, 0,0,0,0};
        tbl[16] = '{0,0,1,500, 1,1,3,0, 500, 0,0,0,0};
        tbl[17] = '{0,0,0,0,   1,1,3,0, 503, 0,0,0,0};
        tbl[18] = '{0,0,1,1023,0,1,0,1, 1023,0,0,0,0};
        tbl[19] = '{0,0,0,0,   1,1,0,1, 1023,0,0,0,0};

        for (int i = 0; i < 20; i++) begin
            clr = tbl[i].c; preset = tbl[i].p; load = tbl[i].l; load_val = 10'(tbl[i].lv);
            en = tbl[i].e; updown = tbl[i].ud; step = 4'(tbl[i].st); mode = 2'(tbl[i].md);
            @(posedge clk);
            model_clock();
            #1;
            check($sformatf("vec%0d", i), outs_a,
                  {10'(tbl[i].cnt), tbl[i].tc, tbl[i].ovf, tbl[i].udf, tbl[i].done});
            check($sformatf("vec%0d_b", i), outs_b, model_vec(1));
        end

        // Asynchronous reset between edges at count 700, then resume from MIN_VAL
        idle(); load = 1; load_val = 10'd700;
        tick("load700");
        idle(); en = 1; updown = 1; step = 4'd1;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_a", outs_a, 14'd0);
        check("async_rst_b", outs_b, 14'd0);
        tick("rst_held");
        #4 rst_n = 1'b1;
        tick("rst_resume");
        check("resume_cnt", outs_a, {10'd1, 4'b0000});

        // Clamp against the overridden MAX_VAL
        idle(); clr = 1; tick("clamp_clr");
        idle(); load = 1; load_val = 10'd1023; tick("clamp_load");
        check("clamp_900", outs_b, {10'd900, 4'b0000});

        // Randomized run
        bias = 5;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) bias = $urandom_range(1, 9);
            clr    = ($urandom_range(0, 99) < 2);
            preset = ($urandom_range(0, 99) < 3);
            load   = ($urandom_range(0, 99) < 5);
            en     = ($urandom_range(0, 99) < 75);
            updown = ($urandom_range(0, 9) < bias);
            step   = 4'($urandom_range(0, 15));
            mode   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       load_val = 10'($urandom);
                1:       load_val = 10'($urandom_range(0, 15));
                default: load_val = 10'($urandom_range(890, 1023));
            endcase
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_updown_param.md
COUNTER_UPDOWN_PARAM -- requirements
Module: counter_updown_param

Interface
REQ-001 Parameter WIDTH, default 10, counter width in bits (2..32).
REQ-002 Parameter MIN_VAL, default 0, lower count bound.
REQ-003 Parameter MAX_VAL, default 1023, upper count bound; MIN_VAL < MAX_VAL < 2**WIDTH.
REQ-004 Parameter PRESET_VAL, default 253, value loaded by preset_in; MIN_VAL <= PRESET_VAL <= MAX_VAL.
REQ-005 Parameter STEP_W, default 4, width of step_in.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clk_in  input  1  sole clock, all state on rising edge.
REQ-008 rst_n_in  input  1  asynchronous active-low reset.
REQ-009 clr_in  input  1  synchronous clear to MIN_VAL, also clears sticky flags.
REQ-010 preset_in  input  1  synchronous load of PRESET_VAL.
REQ-011 load_in  input  1  synchronous load of load_val_in.
REQ-012 load_val_in  input  WIDTH  value for load_in.
REQ-013 en_in  input  1  count enable.
REQ-014 updown_in  input  1  1 = count up, 0 = count down.
REQ-015 step_in  input  STEP_W  increment/decrement magnitude per enabled cycle.
REQ-016 mode_in  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-017 count_out  output  WIDTH  registered count.
REQ-018 tc_out  output  1  registered terminal-count pulse.
REQ-019 ovf_out / udf_out  output  1 each  sticky overflow / underflow flags.
REQ-020 done_out  output  1  high while in one-shot DONE state.

Function
REQ-021 Priority per cycle SHALL be clr_in > preset_in > load_in > en_in; lower-priority inputs ignored that cycle.
REQ-022 load_val_in outside [MIN_VAL, MAX_VAL] SHALL be clamped to the nearer bound.
REQ-023 Enabled count: candidate = count ± step_in, computed at WIDTH+STEP_W+1 bits, no intermediate truncation.
REQ-024 step_in = 0 SHALL hold count and raise no events; step_in > MAX_VAL-MIN_VAL+1 is illegal (bench assertion).
REQ-025 Up past MAX_VAL: wrap -> MIN_VAL + (cand - MAX_VAL - 1); saturate -> MAX_VAL; one-shot -> MAX_VAL; ovf_out set.
REQ-026 Down past MIN_VAL: wrap -> MAX_VAL - (MIN_VAL - cand - 1); saturate -> MIN_VAL; one-shot -> MIN_VAL; udf_out set.
REQ-027 tc_out SHALL be high exactly one cycle after any enabled count whose candidate equals or passes the bound in the count direction (MAX_VAL up, MIN_VAL down), in all modes, including repeated attempts while saturated.
REQ-028 FSM states RUN, DONE; RUN -> DONE when mode 10 and REQ-027 condition occurs; DONE -> RUN only on clr_in, preset_in or load_in.
REQ-029 In DONE, en_in SHALL be ignored, count held, no tc/ovf/udf updates; done_out = (state == DONE).
REQ-030 ovf_out/udf_out remain set until clr_in or reset; preset/load do not clear them.
REQ-031 Load/preset/clear take effect on count_out one cycle after sampling; count latency one cycle.

Reset
REQ-032 rst_n_in low SHALL immediately force count_out = MIN_VAL, tc_out = 0, ovf_out = 0, udf_out = 0, state RUN, done_out = 0, regardless of clock.
REQ-033 Reset deassertion mid-operation SHALL resume counting from MIN_VAL on the first following rising edge.

Structure
REQ-034 Mode encodings and FSM state encodings SHALL live in shared package counter_pkg.
REQ-035 Next-value/bound arithmetic SHALL be a combinational sub-module counter_nxt_calc; registers and FSM stay in the top.

Verification
REQ-036 Wrap up: load 1020, mode 00, step 5, up, en -> count 1, tc_out pulse, ovf_out set.
REQ-037 Saturate down: load 3, mode 01, step 4, down, en 2 cycles -> count 0 both cycles, tc_out high 2 cycles, udf_out set.
REQ-038 One-shot: load 1021, mode 10, step 1, up, en -> 1022, 1023, done_out high, further en holds 1023; preset_in -> 253, done_out low.
REQ-039 Simultaneous clr_in, preset_in, load_in (val 500), en -> count 0, flags cleared.
REQ-040 Async reset: rst_n_in low between clock edges at count 700 -> count_out 0 before next edge; released -> counting resumes from 0.
REQ-041 Clamp: load_val_in 1023 with MAX_VAL overridden to 900 -> count 900.
